// File: rtl/bram_arbiter_if.sv
// Bus bundle between the two RAM clients, the arbiter and the block RAM.
`timescale 1ns/1ps

interface bram_arbiter_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) ();

    // Requester A
    logic              req_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              gnt_a;
    logic              rvalid_a;
    logic [DATA_W-1:0] rdata_a;

    // Requester B
    logic              req_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic              gnt_b;
    logic              rvalid_b;
    logic [DATA_W-1:0] rdata_b;

    // Block RAM control and data
    logic              ram_w_en;
    logic              ram_r_en;
    logic [ADDR_W-1:0] ram_w_addr;
    logic [ADDR_W-1:0] ram_r_addr;
    logic [DATA_W-1:0] ram_w_data;
    logic [DATA_W-1:0] ram_r_data;

    // Arbiter side: consumes requests and RAM read data, owns grants and RAM strobes
    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        input  ram_r_data,
        output gnt_a, rvalid_a, rdata_a,
        output gnt_b, rvalid_b, rdata_b,
        output ram_w_en, ram_r_en, ram_w_addr, ram_r_addr, ram_w_data
    );

    // Client/RAM side: drives requests and RAM read data
    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        output ram_r_data,
        input  gnt_a, rvalid_a, rdata_a,
        input  gnt_b, rvalid_b, rdata_b,
        input  ram_w_en, ram_r_en, ram_w_addr, ram_r_addr, ram_w_data
    );

endinterface

// File: rtl/bram_arbiter.sv
// Two-client arbiter in front of a single registered-read block RAM.
// One access per clock, round-robin or fixed A-priority, and a tagged
// two-stage read-return pipeline that routes each result to its issuer.
`timescale 1ns/1ps

module bram_arbiter #(
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned PRIORITY_MODE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    bram_arbiter_if.slave bus
);

    localparam bit FIXED_PRIO = (PRIORITY_MODE == 32'd1);

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

    // Arbitration (combinational)
    logic              elig_a_c;
    logic              elig_b_c;
    logic              win_a_c;
    logic              win_b_c;
    logic              sel_we_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;

    // Issue stage
    owner_e            last_grant_q, last_grant_d;
    logic              gnt_a_q, gnt_a_d;
    logic              gnt_b_q, gnt_b_d;
    logic              ram_w_en_q, ram_w_en_d;
    logic              ram_r_en_q, ram_r_en_d;
    logic [ADDR_W-1:0] ram_w_addr_q, ram_w_addr_d;
    logic [ADDR_W-1:0] ram_r_addr_q, ram_r_addr_d;
    logic [DATA_W-1:0] ram_w_data_q, ram_w_data_d;

    // Read tag pipeline: stage 0 rides with the RAM read strobe,
    // stage 1 lines up with ram_r_data being valid
    logic              tag_vld0_q, tag_vld0_d;
    owner_e            tag_own0_q, tag_own0_d;
    logic              tag_vld1_q, tag_vld1_d;
    owner_e            tag_own1_q, tag_own1_d;

    // Read return
    logic              rvalid_a_q, rvalid_a_d;
    logic              rvalid_b_q, rvalid_b_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

    // Pick a winner among requests not currently seeing their own grant
    always_comb begin
        elig_a_c = bus.req_a & ~gnt_a_q;
        elig_b_c = bus.req_b & ~gnt_b_q;
        win_a_c  = 1'b0;
        win_b_c  = 1'b0;
        if (elig_a_c && elig_b_c) begin
            if (FIXED_PRIO || (last_grant_q == OWNER_B)) begin
                win_a_c = 1'b1;
            end else begin
                win_b_c = 1'b1;
            end
        end else begin
            win_a_c = elig_a_c;
            win_b_c = elig_b_c;
        end
        sel_we_c    = win_a_c ? bus.we_a    : bus.we_b;
        sel_addr_c  = win_a_c ? bus.addr_a  : bus.addr_b;
        sel_wdata_c = win_a_c ? bus.wdata_a : bus.wdata_b;
    end

    // Next issue-stage values: grant pulse, RAM strobes, read tag entry
    always_comb begin
        gnt_a_d      = 1'b0;
        gnt_b_d      = 1'b0;
        ram_w_en_d   = 1'b0;
        ram_r_en_d   = 1'b0;
        ram_w_addr_d = ram_w_addr_q;
        ram_r_addr_d = ram_r_addr_q;
        ram_w_data_d = ram_w_data_q;
        last_grant_d = last_grant_q;
        tag_vld0_d   = 1'b0;
        tag_own0_d   = tag_own0_q;
        if (win_a_c || win_b_c) begin
            gnt_a_d      = win_a_c;
            gnt_b_d      = win_b_c;
            last_grant_d = win_a_c ? OWNER_A : OWNER_B;
            if (sel_we_c) begin
                ram_w_en_d   = 1'b1;
                ram_w_addr_d = sel_addr_c;
                ram_w_data_d = sel_wdata_c;
            end else begin
                ram_r_en_d   = 1'b1;
                ram_r_addr_d = sel_addr_c;
                tag_vld0_d   = 1'b1;
                tag_own0_d   = win_a_c ? OWNER_A : OWNER_B;
            end
        end
    end

    // Advance read tags and steer returning RAM data to its owner
    always_comb begin
        tag_vld1_d = tag_vld0_q;
        tag_own1_d = tag_own0_q;
        rvalid_a_d = tag_vld1_q && (tag_own1_q == OWNER_A);
        rvalid_b_d = tag_vld1_q && (tag_own1_q == OWNER_B);
        rdata_a_d  = rdata_a_q;
        rdata_b_d  = rdata_b_q;
        if (rvalid_a_d) begin
            rdata_a_d = bus.ram_r_data;
        end
        if (rvalid_b_d) begin
            rdata_b_d = bus.ram_r_data;
        end
    end

    // State registers; reset flushes in-flight reads and favours A on the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= OWNER_B;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            ram_w_en_q   <= 1'b0;
            ram_r_en_q   <= 1'b0;
            ram_w_addr_q <= '0;
            ram_r_addr_q <= '0;
            ram_w_data_q <= '0;
            tag_vld0_q   <= 1'b0;
            tag_own0_q   <= OWNER_A;
            tag_vld1_q   <= 1'b0;
            tag_own1_q   <= OWNER_A;
            rvalid_a_q   <= 1'b0;
            rvalid_b_q   <= 1'b0;
            rdata_a_q    <= '0;
            rdata_b_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            gnt_a_q      <= gnt_a_d;
            gnt_b_q      <= gnt_b_d;
            ram_w_en_q   <= ram_w_en_d;
            ram_r_en_q   <= ram_r_en_d;
            ram_w_addr_q <= ram_w_addr_d;
            ram_r_addr_q <= ram_r_addr_d;
            ram_w_data_q <= ram_w_data_d;
            tag_vld0_q   <= tag_vld0_d;
            tag_own0_q   <= tag_own0_d;
            tag_vld1_q   <= tag_vld1_d;
            tag_own1_q   <= tag_own1_d;
            rvalid_a_q   <= rvalid_a_d;
            rvalid_b_q   <= rvalid_b_d;
            rdata_a_q    <= rdata_a_d;
            rdata_b_q    <= rdata_b_d;
        end
    end

    assign bus.gnt_a      = gnt_a_q;
    assign bus.gnt_b      = gnt_b_q;
    assign bus.rvalid_a   = rvalid_a_q;
    assign bus.rvalid_b   = rvalid_b_q;
    assign bus.rdata_a    = rdata_a_q;
    assign bus.rdata_b    = rdata_b_q;
    assign bus.ram_w_en   = ram_w_en_q;
    assign bus.ram_r_en   = ram_r_en_q;
    assign bus.ram_w_addr = ram_w_addr_q;
    assign bus.ram_r_addr = ram_r_addr_q;
    assign bus.ram_w_data = ram_w_data_q;

`ifndef SYNTHESIS
    // Structural invariants of the issue and return stages
    a_enables_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(ram_w_en_q && ram_r_en_q));
    a_grants_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(gnt_a_q && gnt_b_q));
    a_rvalid_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(rvalid_a_q && rvalid_b_q));
    a_gnt_a_masked: assert property (@(posedge clk) disable iff (!rst_n)
        gnt_a_q |=> !gnt_a_q);
    a_gnt_b_masked: assert property (@(posedge clk) disable iff (!rst_n)
        gnt_b_q |=> !gnt_b_q);
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: round-robin instance against a transaction-level
// model with its own RAM image, plus a fixed-priority instance for policy checks.
`timescale 1ns/1ps

module tb_bram_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    bram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIORITY_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIORITY_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    // Registered-read block RAM behind dut0
    bit [DW-1:0] mem0 [16];
    always @(posedge clk) begin
        if (bus0.ram_w_en) mem0[bus0.ram_w_addr] <= bus0.ram_w_data;
        if (bus0.ram_r_en) bus0.ram_r_data <= mem0[bus0.ram_r_addr];
    end

    // ROM-like RAM behind dut1: data = {C, addr}
    always @(posedge clk) begin
        if (bus1.ram_r_en) bus1.ram_r_data <= {4'hC, bus1.ram_r_addr};
    end

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Transaction-level model of dut0
    typedef struct {
        int          due;
        bit          own_b;
        bit [DW-1:0] d;
    } rd_t;
    rd_t         rq[$];
    bit [DW-1:0] ref_mem [16];
    bit          pg_a, pg_b, last_b, eg_a, eg_b;
    logic [AW-1:0] ex_w_addr, ex_r_addr;
    logic [DW-1:0] ex_w_data, ex_rdata_a, ex_rdata_b;

    task automatic model_reset();
        pg_a = 0; pg_b = 0; last_b = 1; eg_a = 0; eg_b = 0;
        ex_w_addr = '0; ex_r_addr = '0; ex_w_data = '0;
        ex_rdata_a = '0; ex_rdata_b = '0;
        rq.delete();
    endtask

    task automatic set_a(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus0.req_a = req; bus0.we_a = we; bus0.addr_a = a; bus0.wdata_a = d;
    endtask

    task automatic set_b(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus0.req_b = req; bus0.we_b = we; bus0.addr_b = a; bus0.wdata_b = d;
    endtask

    task automatic rand_a();
        set_a(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
    endtask

    task automatic rand_b();
        set_b(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
    endtask

    // One clock of dut0: predict the cycle from the requests that were
    // presented, then compare every dut0 output against the prediction
    task automatic tick();
        bit d_a, d_b, w_a, w_b, el_a, el_b, ew, er, erva, ervb;
        logic [AW-1:0] a_a, a_b;
        logic [DW-1:0] x_a, x_b;
        d_a = bus0.req_a; w_a = bus0.we_a; a_a = bus0.addr_a; x_a = bus0.wdata_a;
        d_b = bus0.req_b; w_b = bus0.we_b; a_b = bus0.addr_b; x_b = bus0.wdata_b;
        @(posedge clk); #1;
        cyc++;
        el_a = d_a && !pg_a;
        el_b = d_b && !pg_b;
        eg_a = el_a && (!el_b || last_b);
        eg_b = el_b && !eg_a;
        if (eg_a || eg_b) last_b = eg_b;
        ew = 0; er = 0;
        if (eg_a) begin
            if (w_a) begin ew = 1; ex_w_addr = a_a; ex_w_data = x_a; ref_mem[a_a] = x_a; end
            else begin er = 1; ex_r_addr = a_a; rq.push_back('{cyc + 2, 1'b0, ref_mem[a_a]}); end
        end
        if (eg_b) begin
            if (w_b) begin ew = 1; ex_w_addr = a_b; ex_w_data = x_b; ref_mem[a_b] = x_b; end
            else begin er = 1; ex_r_addr = a_b; rq.push_back('{cyc + 2, 1'b1, ref_mem[a_b]}); end
        end
        erva = 0; ervb = 0;
        while (rq.size() > 0 && rq[0].due <= cyc) begin
            if (rq[0].due == cyc) begin
                if (rq[0].own_b) begin ervb = 1; ex_rdata_b = rq[0].d; end
                else begin erva = 1; ex_rdata_a = rq[0].d; end
            end
            void'(rq.pop_front());
        end
        vectors++; if (bus0.gnt_a !== eg_a) begin miscompares++; $display("FAIL cyc%0d gnt_a: got %b want %b", cyc, bus0.gnt_a, eg_a); end
        vectors++; if (bus0.gnt_b !== eg_b) begin miscompares++; $display("FAIL cyc%0d gnt_b: got %b want %b", cyc, bus0.gnt_b, eg_b); end
        vectors++; if (bus0.ram_w_en !== ew) begin miscompares++; $display("FAIL cyc%0d ram_w_en: got %b want %b", cyc, bus0.ram_w_en, ew); end
        vectors++; if (bus0.ram_r_en !== er) begin miscompares++; $display("FAIL cyc%0d ram_r_en: got %b want %b", cyc, bus0.ram_r_en, er); end
        vectors++; if (bus0.ram_w_addr !== ex_w_addr) begin miscompares++; $display("FAIL cyc%0d ram_w_addr: got %h want %h", cyc, bus0.ram_w_addr, ex_w_addr); end
        vectors++; if (bus0.ram_w_data !== ex_w_data) begin miscompares++; $display("FAIL cyc%0d ram_w_data: got %h want %h", cyc, bus0.ram_w_data, ex_w_data); end
        vectors++; if (bus0.ram_r_addr !== ex_r_addr) begin miscompares++; $display("FAIL cyc%0d ram_r_addr: got %h want %h", cyc, bus0.ram_r_addr, ex_r_addr); end
        vectors++; if (bus0.rvalid_a !== erva) begin miscompares++; $display("FAIL cyc%0d rvalid_a: got %b want %b", cyc, bus0.rvalid_a, erva); end
        vectors++; if (bus0.rvalid_b !== ervb) begin miscompares++; $display("FAIL cyc%0d rvalid_b: got %b want %b", cyc, bus0.rvalid_b, ervb); end
        vectors++; if (bus0.rdata_a !== ex_rdata_a) begin miscompares++; $display("FAIL cyc%0d rdata_a: got %h want %h", cyc, bus0.rdata_a, ex_rdata_a); end
        vectors++; if (bus0.rdata_b !== ex_rdata_b) begin miscompares++; $display("FAIL cyc%0d rdata_b: got %h want %h", cyc, bus0.rdata_b, ex_rdata_b); end
        pg_a = eg_a; pg_b = eg_b;
    endtask

    // Present one access on A (or B) and wait for the model to see it granted
    task automatic issue_a(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        set_a(1'b1, we, a, d);
        n = 0;
        do begin tick(); n++; end while (!eg_a && n < 10);
        if (!eg_a) begin miscompares++; $display("FAIL issue_a timeout: got no grant want grant"); end
        set_a(1'b0, we, a, d);
    endtask

    task automatic issue_b(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        set_b(1'b1, we, a, d);
        n = 0;
        do begin tick(); n++; end while (!eg_b && n < 10);
        if (!eg_b) begin miscompares++; $display("FAIL issue_b timeout: got no grant want grant"); end
        set_b(1'b0, we, a, d);
    endtask

    task automatic test_reset();
        logic [37:0] o;
        int rv_seen;
        repeat (3) @(posedge clk);
        #1;
        o = {bus0.gnt_a, bus0.gnt_b, bus0.rvalid_a, bus0.rvalid_b, bus0.ram_w_en, bus0.ram_r_en,
             bus0.ram_w_addr, bus0.ram_r_addr, bus0.ram_w_data, bus0.rdata_a, bus0.rdata_b};
        vectors++; if (o !== '0) begin miscompares++; $display("FAIL reset_state0: got %h want 0", o); end
        o = {bus1.gnt_a, bus1.gnt_b, bus1.rvalid_a, bus1.rvalid_b, bus1.ram_w_en, bus1.ram_r_en,
             bus1.ram_w_addr, bus1.ram_r_addr, bus1.ram_w_data, bus1.rdata_a, bus1.rdata_b};
        vectors++; if (o !== '0) begin miscompares++; $display("FAIL reset_state1: got %h want 0", o); end
        rst_n = 1'b1;
        model_reset();
        // Read of addr 3 granted, then reset lands while it is in flight
        issue_a(1'b0, 4'd3, 8'h00);
        tick();
        rst_n = 1'b0;
        #1;
        o = {bus0.gnt_a, bus0.gnt_b, bus0.rvalid_a, bus0.rvalid_b, bus0.ram_w_en, bus0.ram_r_en,
             bus0.ram_w_addr, bus0.ram_r_addr, bus0.ram_w_data, bus0.rdata_a, bus0.rdata_b};
        vectors++; if (o !== '0) begin miscompares++; $display("FAIL reset_midread: got %h want 0", o); end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rv_seen = 0;
        repeat (5) begin
            tick();
            if (bus0.rvalid_a === 1'b1) rv_seen++;
        end
        vectors++; if (rv_seen !== 0) begin miscompares++; $display("FAIL reset_flush rvalid_a pulses: got %0d want 0", rv_seen); end
    endtask

    task automatic test_write_read();
        int g;
        issue_a(1'b1, 4'd2, 8'hA5);
        vectors++; if ({bus0.gnt_a, bus0.ram_w_en, bus0.ram_r_en} !== 3'b110) begin miscompares++; $display("FAIL wr_strobes: got %b want 110", {bus0.gnt_a, bus0.ram_w_en, bus0.ram_r_en}); end
        vectors++; if ({bus0.ram_w_addr, bus0.ram_w_data} !== {4'd2, 8'hA5}) begin miscompares++; $display("FAIL wr_addr_data: got %h want 2a5", {bus0.ram_w_addr, bus0.ram_w_data}); end
        issue_a(1'b0, 4'd2, 8'h00);
        g = cyc;
        tick();
        tick();
        vectors++; if (cyc !== g + 2 || bus0.rvalid_a !== 1'b1 || bus0.rdata_a !== 8'hA5) begin miscompares++; $display("FAIL rd_after_wr: got rvalid %b data %h want 1 a5", bus0.rvalid_a, bus0.rdata_a); end
        tick();
    endtask

    task automatic test_round_robin();
        bit want_b;
        issue_a(1'b0, 4'd7, 8'h00);
        tick();
        tick();
        rand_a();
        rand_b();
        for (int i = 0; i < 16; i++) begin
            tick();
            want_b = (i % 2 == 0);
            vectors++; if ({bus0.gnt_a, bus0.gnt_b} !== {!want_b, want_b}) begin miscompares++; $display("FAIL rr_seq i=%0d: got ab=%b%b want %b%b", i, bus0.gnt_a, bus0.gnt_b, !want_b, want_b); end
            if (eg_a) rand_a();
            if (eg_b) rand_b();
        end
        bus0.req_a = 1'b0;
        bus0.req_b = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_priority();
        bit wa;
        bus1.req_a = 1'b1; bus1.addr_a = 4'd5;
        bus1.req_b = 1'b1; bus1.addr_b = 4'd9;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            wa = (i % 2 == 1);
            vectors++; if ({bus1.gnt_a, bus1.gnt_b} !== {wa, !wa}) begin miscompares++; $display("FAIL prio_gnt i=%0d: got ab=%b%b want %b%b", i, bus1.gnt_a, bus1.gnt_b, wa, !wa); end
            vectors++; if ({bus1.ram_r_en, bus1.ram_w_en, bus1.ram_r_addr} !== {2'b10, (wa ? 4'd5 : 4'd9)}) begin miscompares++; $display("FAIL prio_ram i=%0d: got r%b w%b a%h", i, bus1.ram_r_en, bus1.ram_w_en, bus1.ram_r_addr); end
            if (i >= 3) begin
                vectors++; if ({bus1.rvalid_a, bus1.rvalid_b} !== {wa, !wa}) begin miscompares++; $display("FAIL prio_rvalid i=%0d: got ab=%b%b want %b%b", i, bus1.rvalid_a, bus1.rvalid_b, wa, !wa); end
                vectors++; if ((wa ? bus1.rdata_a : bus1.rdata_b) !== (wa ? 8'hC5 : 8'hC9)) begin miscompares++; $display("FAIL prio_rdata i=%0d: got %h", i, wa ? bus1.rdata_a : bus1.rdata_b); end
            end
        end
        bus1.req_a = 1'b0;
        bus1.req_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // A wins a tie even right after being granted itself
        bus1.req_a = 1'b1;
        @(posedge clk); #1;
        vectors++; if (bus1.gnt_a !== 1'b1) begin miscompares++; $display("FAIL prio_lone_a: got %b want 1", bus1.gnt_a); end
        bus1.req_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus1.req_a = 1'b1;
        bus1.req_b = 1'b1;
        @(posedge clk); #1;
        vectors++; if ({bus1.gnt_a, bus1.gnt_b} !== 2'b10) begin miscompares++; $display("FAIL prio_tie: got ab=%b%b want 10", bus1.gnt_a, bus1.gnt_b); end
        bus1.req_a = 1'b0;
        bus1.req_b = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int start, oga, ogb, n;
        issue_a(1'b1, 4'd1, 8'h11);
        issue_b(1'b1, 4'd4, 8'h44);
        tick();
        tick();
        set_a(1'b1, 1'b0, 4'd1, 8'h00);
        set_b(1'b1, 1'b0, 4'd4, 8'h00);
        start = cyc;
        oga = -1; ogb = -1; n = 0;
        while ((oga < 0 || ogb < 0) && n < 10) begin
            tick(); n++;
            if (bus0.gnt_a === 1'b1 && oga < 0) oga = cyc;
            if (bus0.gnt_b === 1'b1 && ogb < 0) ogb = cyc;
            if (eg_a) bus0.req_a = 1'b0;
            if (eg_b) bus0.req_b = 1'b0;
        end
        bus0.req_a = 1'b0;
        bus0.req_b = 1'b0;
        vectors++; if (oga !== start + 1 || ogb !== start + 2) begin miscompares++; $display("FAIL b2b_grants: got a@%0d b@%0d want a@%0d b@%0d", oga, ogb, start + 1, start + 2); end
        while (cyc < start + 3) tick();
        vectors++; if ({bus0.rvalid_a, bus0.rvalid_b, bus0.rdata_a} !== {2'b10, 8'h11}) begin miscompares++; $display("FAIL b2b_rvalid_a: got %b%b %h want 10 11", bus0.rvalid_a, bus0.rvalid_b, bus0.rdata_a); end
        tick();
        vectors++; if ({bus0.rvalid_a, bus0.rvalid_b, bus0.rdata_b, bus0.rdata_a} !== {2'b01, 8'h44, 8'h11}) begin miscompares++; $display("FAIL b2b_rvalid_b: got %b%b %h %h want 01 44 11", bus0.rvalid_a, bus0.rvalid_b, bus0.rdata_b, bus0.rdata_a); end
        repeat (2) tick();
    endtask

    task automatic test_single_request();
        int grants;
        rand_b();
        grants = 0;
        tick();
        if (bus0.gnt_b === 1'b1) grants++;
        vectors++; if (bus0.gnt_b !== 1'b1) begin miscompares++; $display("FAIL single_gnt: got %b want 1", bus0.gnt_b); end
        tick();
        if (bus0.gnt_b === 1'b1) grants++;
        vectors++; if (bus0.gnt_b !== 1'b0) begin miscompares++; $display("FAIL single_mask: got %b want 0", bus0.gnt_b); end
        bus0.req_b = 1'b0;
        repeat (3) begin
            tick();
            if (bus0.gnt_b === 1'b1) grants++;
        end
        vectors++; if (grants !== 1) begin miscompares++; $display("FAIL single_count: got %0d want 1", grants); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick();
            if (eg_a) begin
                if ($urandom_range(0, 9) < 6) rand_a(); else bus0.req_a = 1'b0;
            end else if (bus0.req_a !== 1'b1 && $urandom_range(0, 9) < 4) begin
                rand_a();
            end
            if (eg_b) begin
                if ($urandom_range(0, 9) < 6) rand_b(); else bus0.req_b = 1'b0;
            end else if (bus0.req_b !== 1'b1 && $urandom_range(0, 9) < 4) begin
                rand_b();
            end
        end
        bus0.req_a = 1'b0;
        bus0.req_b = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
        bus1.req_a = 1'b0; bus1.we_a = 1'b0; bus1.addr_a = '0; bus1.wdata_a = '0;
        bus1.req_b = 1'b0; bus1.we_b = 1'b0; bus1.addr_b = '0; bus1.wdata_b = '0;
        model_reset();
        test_reset();
        test_write_read();
        test_round_robin();
        test_priority();
        test_back_to_back();
        test_single_request();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares one `_block_RAM` instance (registered read, 1-cycle read latency) between two requesters, A and B.
- Issues at most one RAM access per clock and selects between requesters by round-robin or fixed priority.
- Returns read data to the requester that issued the read.
- Sits between the LED/state logic (or any two clients) and the `_block_RAM` instance, and owns all RAM control strobes.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM data width.
- PRIORITY_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority with A always winning.

Ports:
- clk  in  1  system clock (12 MHz); single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- req_a  in  1  requester A access request; held until gnt_a.
- we_a  in  1  A: 1 = write, 0 = read; stable while req_a is high.
- addr_a  in  ADDR_W  A address.
- wdata_a  in  DATA_W  A write data.
- gnt_a  out  1  one-cycle grant pulse to A.
- rvalid_a  out  1  one-cycle pulse: rdata_a holds A's read result.
- rdata_a  out  DATA_W  A read data, held until A's next read completes.
- req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: identical set for requester B.
- ram_w_en  out  1  RAM write enable.
- ram_r_en  out  1  RAM read enable.
- ram_w_addr  out  ADDR_W  RAM write address.
- ram_r_addr  out  ADDR_W  RAM read address.
- ram_w_data  out  DATA_W  RAM write data.
- ram_r_data  in  DATA_W  RAM registered read data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs go to 0.
  - last_grant goes to B, so A wins the first tie.
  - The in-flight read pipeline is flushed.
  - A read in flight at reset never produces rvalid.
- Request sampling:
  - On each clk edge with rst_n high, the arbiter samples eligible requests.
  - req_x is eligible only when gnt_x is 0. This masks the cycle in which the requester is still seeing its grant, so no double issue occurs.
- Arbitration:
  - Exactly one eligible request: grant it.
  - Both eligible, PRIORITY_MODE = 0: grant the requester that is not last_grant.
  - Both eligible, PRIORITY_MODE = 1: grant A.
  - last_grant updates on every grant.
- Issue stage (registered), for a request sampled at the end of cycle K, in cycle K+1:
  - gnt_x = 1.
  - Write: ram_w_en = 1, ram_w_addr = addr_x, ram_w_data = wdata_x, ram_r_en = 0.
  - Read: ram_r_en = 1, ram_r_addr = addr_x, ram_w_en = 0.
  - ram_w_en and ram_r_en are never both 1 in the same cycle.
  - With no grant, both enables are 0; addresses and data hold their last values.
- Read return, for a read granted in K+1:
  - The RAM captures at the end of K+1, and ram_r_data is valid in K+2.
  - An owner tag (A/B) plus a valid bit follow the read through a 2-stage pipeline.
  - At the end of K+2, rdata_owner <= ram_r_data.
  - rvalid_owner = 1 for cycle K+3 only.
- Write completion: the write completes at the end of K+1; there is no response beyond gnt.
- Throughput:
  - One access per cycle overall.
  - A single requester holding req continuously is granted every other cycle, because of the mask.
  - Two continuously requesting clients alternate A, B, A, B, … in mode 0.
- Hazards and boundaries:
  - A read of an address written in the immediately preceding grant returns the new data, since the write completes before the read issues.
  - Address wrap: none; addresses are used verbatim.
  - Reads from A and B may be in flight at the same time. Each tag routes its own result.
  - rvalid_a and rvalid_b never assert in the same cycle.
  - Holding req across reset: after rst_n rises, the request is re-arbitrated from the reset state.

Test Plan:
- Reset with rst_n = 0 mid-read (read to addr 3 granted, rst_n low in the next cycle) -> all outputs 0; no rvalid_a ever pulses for that read.
- A writes 8'hA5 to addr 2 (req_a=1, we_a=1, held until gnt), then reads addr 2 -> gnt_a 1 cycle after each sampled request; ram_w_en=1/ram_w_addr=2/ram_w_data=A5 with the first gnt_a; rvalid_a=1 and rdata_a=8'hA5 exactly 2 cycles after the read's gnt_a.
- req_a and req_b both held high continuously, mode 0 -> gnt sequence A, B, A, B; ram_w_en and ram_r_en never both 1; every granted read gets its rvalid to the correct side.
- Same stimulus with PRIORITY_MODE=1 -> A granted every other cycle; B granted only in A's masked cycles.
- Back-to-back reads: A reads addr 1 (preloaded 8'h11), B reads addr 4 (preloaded 8'h44) on consecutive grants -> rvalid_a with 8'h11, then rvalid_b with 8'h44 one cycle later; rdata_a still holds 8'h11.
- Single request, no competitor: req_b pulse held 1 cycle until gnt_b -> exactly one grant, no repeat grant while gnt_b is high.
